pipe_cla_add_sub: RTL and testbench
===================================

PIPE_CLA_ADD_SUB -- requirements
Module: pipe_cla_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values 8, 16, 32, 64 (multiple of 8).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ain  input  WIDTH  operand A.
REQ-005 SHALL have port bin  input  WIDTH  operand B.
REQ-006 SHALL have port cin  input  1  carry in, used by ADD and SBC only.
REQ-007 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 SBC, 11 RSB.
REQ-008 SHALL have port in_valid  input  1  operand beat valid.
REQ-009 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-010 SHALL have port sum  output  WIDTH  result.
REQ-011 SHALL have port cout  output  1  carry out of MSB (SUB/SBC/RSB: 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-013 SHALL have port zero  output  1  sum == 0.
REQ-014 SHALL have port out_valid  output  1  result beat valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-016 SHALL compute ADD = A+B+cin, SUB = A+~B+1, SBC = A+~B+cin, RSB = B+~A+1, all modulo 2^WIDTH.
REQ-017 SHALL build the adder from 4-bit CLA groups with group-level lookahead; no ripple across groups within a stage.
REQ-018 SHALL use two pipeline stages: stage 1 adds low WIDTH/2 bits and registers low sum, mid carry, conditioned high operands; stage 2 adds high half with registered mid carry.
REQ-019 SHALL have latency exactly 2 cycles from accepted beat (in_valid && in_ready) to out_valid, with no stalls.
REQ-020 SHALL sustain throughput of one beat per cycle while out_ready is held high.
REQ-021 SHALL define advance = !out_valid || out_ready, and drive in_ready = advance && !rst.
REQ-022 SHALL hold both stage registers, including their valid bits, unchanged when advance is 0 (backpressure stall, no beat lost or duplicated).
REQ-023 SHALL load a bubble (valid 0) into stage 1 when advance is 1 and in_valid is 0.
REQ-024 SHALL keep sum, cout, ovf and zero stable while out_valid && !out_ready.
REQ-025 SHALL compute ovf = (MSB of conditioned A == MSB of conditioned B) && (MSB of sum != that MSB), evaluated on the wrapped result.
REQ-026 SHALL compute zero from the final sum as driven (after saturation when enabled).
REQ-027 SHALL ignore cin for SUB and RSB.
REQ-028 SHALL ignore ain, bin, cin and op when in_valid is 0.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear both stage valid bits and set sum, cout, ovf, zero to 0 and out_valid to 0.
REQ-030 SHALL drop any in-flight beats when rst asserts mid-operation; the first accepted beat after rst deasserts appears 2 cycles later.
REQ-031 SHALL hold in_ready at 0 while rst is high.

Configuration
REQ-032 SHALL provide macro CLA_ADD_SUB_SAT_EN. When defined, on ovf=1 sum clamps to the signed maximum (positive overflow) or minimum (negative overflow); ovf still reads 1; cout is unchanged. When undefined, sum wraps and no saturation logic exists.

Verification
REQ-033 SHALL check: WIDTH=16, ADD, A=0xFFFF, B=0x0001, cin=0 -> 2 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
REQ-034 SHALL check: SUB, A=0x8000, B=0x0001 -> sum=0x7FFF, ovf=1, cout=1 without macro; with CLA_ADD_SUB_SAT_EN sum=0x8000, ovf=1.
REQ-035 SHALL check: RSB, A=0x0005, B=0x0003 -> sum=0xFFFE, cout=0, ovf=0; SBC, A=0x0005, B=0x0003, cin=0 -> sum=0x0001, cout=1.
REQ-036 SHALL check: 8 back-to-back beats with out_ready=1 -> 8 results on consecutive cycles, in order, first one 2 cycles after first accept.
REQ-037 SHALL check: out_ready=0 for 5 cycles with 3 beats offered -> in_ready falls once out_valid is 1; held result stable; after release, all accepted beats emerge in order with none lost or duplicated.
REQ-038 SHALL check: rst for 1 cycle with 2 beats in flight -> out_valid=0 and outputs 0 next cycle; no stale beat is ever emitted.

Source files
------------

// File: rtl/pipe_cla_add_sub.sv
// Two-stage pipelined add/subtract built from 4-bit carry-lookahead groups.
// Stage 1 adds the low half and registers the mid carry with the conditioned
// high operands. Stage 2 adds the high half and registers the flags.
// Optional feature: define CLA_ADD_SUB_SAT_EN to clamp on signed overflow.
module pipe_cla_add_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned NG = H / 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SBC = 2'b10,
        OP_RSB = 2'b11
    } op_e;

    // Half-width CLA: carries into every group are computed directly from the
    // group generate/propagate terms, so no carry ripples between groups.
    function automatic logic [H:0] cla_add(input logic [H-1:0] a,
                                           input logic [H-1:0] b,
                                           input logic         c0);
        logic [H-1:0]  g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          term;
        g = a & b;
        p = a ^ b;
        for (int unsigned k = 0; k < NG; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc    = '0;
        gc[0] = c0;
        for (int unsigned k = 1; k <= NG; k++) begin
            term = c0;
            for (int unsigned m = 0; m < k; m++) term = term & gp[m];
            gc[k] = term;
            for (int unsigned j = 0; j < k; j++) begin
                term = gg[j];
                for (int unsigned m = j + 1; m < k; m++) term = term & gp[m];
                gc[k] = gc[k] | term;
            end
        end
        c = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return {gc[NG], p ^ c};
    endfunction

    logic [WIDTH-1:0] cond_a, cond_b;
    logic             cond_c;
    logic [H:0]       lo_res, hi_res;
    logic             advance;

    logic             s1_valid;
    logic [H-1:0]     s1_lo, s1_ahi, s1_bhi;
    logic             s1_carry;

    logic [WIDTH-1:0] final_sum;
    logic             ovf_c;

    // Map each operation onto a single A + B + carry addition.
    always_comb begin
        cond_a = ain;
        cond_b = bin;
        cond_c = cin;
        case (op_e'(op))
            OP_ADD: begin cond_a = ain; cond_b = bin;  cond_c = cin;  end
            OP_SUB: begin cond_a = ain; cond_b = ~bin; cond_c = 1'b1; end
            OP_SBC: begin cond_a = ain; cond_b = ~bin; cond_c = cin;  end
            OP_RSB: begin cond_a = bin; cond_b = ~ain; cond_c = 1'b1; end
            default: ;
        endcase
    end

    // Handshake: whole pipeline moves unless a held result is not taken.
    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = advance && !rst;
        lo_res   = cla_add(cond_a[H-1:0], cond_b[H-1:0], cond_c);
    end

    // Stage 1 register: low-half sum, mid carry and conditioned high operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_carry <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo    <= lo_res[H-1:0];
                s1_carry <= lo_res[H];
                s1_ahi   <= cond_a[WIDTH-1:H];
                s1_bhi   <= cond_b[WIDTH-1:H];
            end
        end
    end

    // Stage 2 combinational: high-half add, overflow detect, optional clamp.
    always_comb begin
        hi_res = cla_add(s1_ahi, s1_bhi, s1_carry);
        ovf_c  = (s1_ahi[H-1] == s1_bhi[H-1]) && (hi_res[H-1] != s1_ahi[H-1]);
`ifdef CLA_ADD_SUB_SAT_EN
        if (ovf_c)
            final_sum = {s1_ahi[H-1], {(WIDTH-1){~s1_ahi[H-1]}}};
        else
            final_sum = {hi_res[H-1:0], s1_lo};
`else
        final_sum = {hi_res[H-1:0], s1_lo};
`endif
    end

    // Output register: result and flags, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= final_sum;
                cout <= hi_res[H];
                ovf  <= ovf_c;
                zero <= (final_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipe_cla_add_sub.sv
// Self-checking bench for pipe_cla_add_sub (WIDTH=16) against an arithmetic
// reference model with a queue of expected results and their due cycles.
module tb_pipe_cla_add_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ain, bin;
    logic        cin;
    logic [1:0]  op;
    logic        in_valid, in_ready;
    logic [15:0] sum;
    logic        cout, ovf, zero, out_valid, out_ready;

    always #5 clk = ~clk;

    pipe_cla_add_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ain(ain), .bin(bin), .cin(cin), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
        int          stalls;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          pops = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] last_sum;
    logic        last_cout, last_ovf, last_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic [1:0] o);
        exp_t        e;
        logic [15:0] x, y;
        logic        ci;
        int unsigned tot;
        int          st;
        case (o)
            2'd0:    begin x = a; y = b;  ci = c;    end
            2'd1:    begin x = a; y = ~b; ci = 1'b1; end
            2'd2:    begin x = a; y = ~b; ci = c;    end
            default: begin x = b; y = ~a; ci = 1'b1; end
        endcase
        tot  = 32'(x) + 32'(y) + 32'(ci);
        st   = int'($signed(x)) + int'($signed(y)) + int'(ci);
        e.s  = tot[15:0];
        e.co = tot[16];
        e.ov = (st > 32767) || (st < -32768);
`ifdef CLA_ADD_SUB_SAT_EN
        if (e.ov) e.s = (st > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z      = (e.s == 16'h0000);
        e.acc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, check before the rising edge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [1:0] o, input logic ordy,
                         input logic r, output logic accepted);
        logic exp_ov;
        exp_t e;
        in_valid = v; ain = a; bin = b; cin = c; op = o; out_ready = ordy; rst = r;
        accepted = 1'b0;
        #1;
        if (r) begin
            chk("in_ready_during_rst", in_ready, 1'b0);
        end else begin
            exp_ov = (q.size() > 0) && (cyc == q[0].acc + 2 + (stall_cnt - q[0].stalls));
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, !exp_ov || ordy);
            if (exp_ov) begin
                chk("sum", sum, q[0].s);
                chk("cout", cout, q[0].co);
                chk("ovf", ovf, q[0].ov);
                chk("zero", zero, q[0].z);
                last_sum = sum; last_cout = cout; last_ovf = ovf; last_zero = zero;
                if (ordy) begin
                    void'(q.pop_front());
                    pops++;
                end else begin
                    stall_cnt++;
                end
            end
            if (v && (!exp_ov || ordy)) begin
                e        = model(a, b, c, o);
                e.acc    = cyc;
                e.stalls = stall_cnt;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        if (r) q.delete();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        logic dummy;
        cycle(1'b0, $urandom, $urandom, 1'($urandom), 2'($urandom), ordy, 1'b0, dummy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic one(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [1:0] o);
        logic acc;
        cycle(1'b1, a, b, c, o, 1'b1, 1'b0, acc);
        chk("single_accept", acc, 1'b1);
        drain();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_zero", zero, 1'b0);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   p0;
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        int   nxt;

        // Reset state.
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk_reset_outputs();
        idle(1'b1);

        // ADD wrap to zero.
        one(16'hFFFF, 16'h0001, 1'b0, 2'd0);
        chk("add_wrap_sum", last_sum, 16'h0000);
        chk("add_wrap_cout", last_cout, 1'b1);
        chk("add_wrap_zero", last_zero, 1'b1);
        chk("add_wrap_ovf", last_ovf, 1'b0);

        // SUB with negative overflow.
        one(16'h8000, 16'h0001, 1'b0, 2'd1);
`ifdef CLA_ADD_SUB_SAT_EN
        chk("sub_ovf_sum", last_sum, 16'h8000);
`else
        chk("sub_ovf_sum", last_sum, 16'h7FFF);
`endif
        chk("sub_ovf_ovf", last_ovf, 1'b1);
        chk("sub_ovf_cout", last_cout, 1'b1);

        // RSB and SBC; cin set on RSB must be ignored.
        one(16'h0005, 16'h0003, 1'b1, 2'd3);
        chk("rsb_sum", last_sum, 16'hFFFE);
        chk("rsb_cout", last_cout, 1'b0);
        chk("rsb_ovf", last_ovf, 1'b0);
        one(16'h0005, 16'h0003, 1'b0, 2'd2);
        chk("sbc_sum", last_sum, 16'h0001);
        chk("sbc_cout", last_cout, 1'b1);

        // Eight back-to-back beats with downstream always ready.
        p0 = pops;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
                  1'b1, 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("b2b_accepts", n_acc, 8);
        drain();
        chk("b2b_results", pops - p0, 8);

        // Backpressure: out_ready low for 5 cycles while 3 beats are offered.
        for (int i = 0; i < 3; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
        end
        p0 = pops;
        nxt = 0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (nxt < 3) cycle(1'b1, ba[nxt], bb[nxt], 1'b0, 2'd0, 1'b0, 1'b0, acc);
            else         cycle(1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0, acc);
            if (acc) begin nxt++; n_acc++; end
        end
        chk("stall_accepts", n_acc, 2);
        for (int i = 0; i < 10 && nxt < 3; i++) begin
            cycle(1'b1, ba[nxt], bb[nxt], 1'b0, 2'd0, 1'b1, 1'b0, acc);
            if (acc) nxt++;
        end
        chk("stall_all_offered", nxt, 3);
        drain();
        chk("stall_results", pops - p0, 3);

        // Randomized traffic with random valid and ready.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, acc);
        end
        drain();

        // Boundary operands on every op.
        for (int o = 0; o < 4; o++) begin
            cycle(1'b1, 16'h7FFF, 16'h8000, 1'b1, 2'(o), 1'b1, 1'b0, acc);
            cycle(1'b1, 16'h8000, 16'h7FFF, 1'b0, 2'(o), 1'b1, 1'b0, acc);
            cycle(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 2'(o), 1'b1, 1'b0, acc);
            cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 2'(o), 1'b1, 1'b0, acc);
        end
        drain();

        // Reset with two beats in flight.
        cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 2'd0, 1'b1, 1'b0, acc);
        cycle(1'b1, 16'h3333, 16'h4444, 1'b0, 2'd0, 1'b1, 1'b0, acc);
        cycle(1'b1, 16'h5555, 16'h6666, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk_reset_outputs();
        for (int i = 0; i < 4; i++) idle(1'b1);
        one(16'h00F0, 16'h000F, 1'b1, 2'd0);
        chk("post_rst_sum", last_sum, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
